ex_mem_wb_backend: RTL and testbench
====================================

Name: ex_mem_wb_backend

Overview:
- Back half of the 5-stage pipeline; consumes the decode-stage control/operand bundle and closes the loop to decode.
- Holds the ID/EX, EX/MEM and MEM/WB slots and the EX operand-forwarding muxes.
- Detects load-use hazards and drives stall.
- Drives the writeback triple (wb_dest, wb_en, wb_data) back to the register file; the ALU and data memory are external, combinational.

Parameters:
WORD, 32, datapath width (shared `WORD constant)
RADDR, 5, register index width

Ports:
clk  in  1  pipeline clock, all slots update on posedge
rst  in  1  asynchronous active-low reset
id_mem_w, id_mem_r, id_wb_en, id_terminate  in  1 each  decode control bits
id_alu_op  in  4  ALU operation
id_reg_rs, id_reg_rt, id_reg_dest  in  RADDR  source/dest indices; 0 = no dependency
id_alu_1, id_alu_2, id_st_data  in  WORD  decode operands
ex_alu_op  out  4  registered opcode to external ALU
ex_opa, ex_opb  out  WORD  forwarded ALU operands
alu_result  in  WORD  external ALU result for EX slot
mem_addr, mem_wdata  out  WORD  MEM-slot address / store data
mem_we, mem_re  out  1  MEM-slot strobes
mem_rdata  in  WORD  combinational load data
stall  out  1  load-use hazard, holds IF/ID
wb_dest  out  RADDR  writeback register
wb_en  out  1  writeback enable
wb_data  out  WORD  writeback value
halted  out  1  sticky, terminate retired

Behaviour:
- Reset (rst=0, async): all slot valid/control bits, indices and data clear to 0, so every output is 0 including stall and halted. First posedge after release samples normally.
- Each slot holds: valid, mem_w, mem_r, wb_en, terminate, alu_op, rs, rt, dest, op1, op2, st_data, result.
- EX slot capture:
  - When stall=1, capture a bubble (all control bits 0).
  - Otherwise capture the id_* bundle with valid=1.
- MEM slot captures the EX slot plus alu_result and forwarded store data.
- WB slot captures the MEM slot; its result is mem_rdata if mem_r=1, else the ALU result.
- Latency: a decode bundle drives wb_* exactly 3 cycles later.
- Forwarding (EX operands; the same logic applies to store data using rt):
  - A source index of 0 is never forwarded.
  - MEM slot wins when its wb_en=1, mem_r=0 and dest matches; value is its ALU result.
  - Else WB slot wins when its wb_en=1 and dest matches; value is wb_data.
  - Else the captured operand is used.
  - ex_opa is forwarded only via rs, ex_opb only via rt. Decode zeroes an index when the operand is an immediate or shamt.
- Register-file coverage: writes on negedge make same-cycle WB data visible to decode, so no ID-side bypass is needed.
- Stall (combinational):
  - Asserted when EX slot valid & mem_r & wb_en & dest!=0 & (dest==id_reg_rs | dest==id_reg_rt).
  - Lasts exactly one cycle per load-use; the bubble then removes the hazard.
  - A load followed by two dependents gives one stall, then a WB-slot forward.
- wb_en: = WB slot wb_en & valid & ~halted. A write to dest 0 still asserts wb_en; the register file ignores r0.
- Halt:
  - halted sets on the posedge after the WB slot holds terminate=1.
  - Once set it stays set until reset, freezes all slots, and forces wb_en, mem_we, mem_re and stall to 0.
- Reset mid-operation discards all in-flight slots; no partial writeback.

Decomposition:
- Shared constants header: `WORD, and slot field widths as macros RADDR_W, ALUOP_W.
- One sub-module, fwd_select: per-operand priority mux taking index, captured value and both slot (wb_en, mem_r, dest, value) tuples; instantiated three times (opa, opb, store data).

Test Plan:
- Reset: hold rst=0 with nonzero inputs -> all outputs 0. Release -> bundle dest=3, alu_result=0x11 -> wb_dest=3, wb_en=1, wb_data=0x11 on the 3rd posedge.
- EX-EX forward: add r1 (result 0x5), next instruction rs=1 with id_alu_1=0xDEAD -> ex_opa=0x5; rs=0 -> no forward.
- Priority: r2=0xA then r2=0xB, then consumer rt=2 -> ex_opb=0xB (MEM slot), not 0xA.
- Load-use: lw r4 (mem_rdata=0x77), next rs=4 -> stall=1 for one cycle, bubble inserted, consumer then sees ex_opa=0x77. Same with rs=0 and dest=0 -> stall=0.
- Store-data forward: add r6=0x99, then sw with rt=6 -> mem_wdata=0x99, mem_we=1.
- Halt: terminate bundle -> halted=1 four posedges after issue. Later bundles -> wb_en=0. Async rst pulse -> halted=0.

Source files
------------

// File: rtl/ex_mem_wb_backend_pkg.sv
// Shared widths and pipeline slot layout for the
// execute / memory / writeback backend.
`ifndef EX_MEM_WB_BACKEND_DEFS
`define EX_MEM_WB_BACKEND_DEFS
`define WORD 32
`define RADDR_W 5
`define ALUOP_W 4
`endif

package ex_mem_wb_backend_pkg;
    localparam int WORD  = `WORD;
    localparam int RADDR = `RADDR_W;
    localparam int ALUOP = `ALUOP_W;

    typedef struct packed {
        logic             valid;
        logic             mem_w;
        logic             mem_r;
        logic             wb_en;
        logic             terminate;
        logic [ALUOP-1:0] alu_op;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] dest;
        logic [WORD-1:0]  op1;
        logic [WORD-1:0]  op2;
        logic [WORD-1:0]  st_data;
        logic [WORD-1:0]  result;
    } slot_t;
endpackage

// File: rtl/ex_mem_wb_backend_if.sv
// Decode bundle, ALU, data memory and writeback
// signals between the backend and its surroundings.
interface ex_mem_wb_backend_if;
    import ex_mem_wb_backend_pkg::*;

    logic             id_mem_w;
    logic             id_mem_r;
    logic             id_wb_en;
    logic             id_terminate;
    logic [ALUOP-1:0] id_alu_op;
    logic [RADDR-1:0] id_reg_rs;
    logic [RADDR-1:0] id_reg_rt;
    logic [RADDR-1:0] id_reg_dest;
    logic [WORD-1:0]  id_alu_1;
    logic [WORD-1:0]  id_alu_2;
    logic [WORD-1:0]  id_st_data;
    logic [ALUOP-1:0] ex_alu_op;
    logic [WORD-1:0]  ex_opa;
    logic [WORD-1:0]  ex_opb;
    logic [WORD-1:0]  alu_result;
    logic [WORD-1:0]  mem_addr;
    logic [WORD-1:0]  mem_wdata;
    logic             mem_we;
    logic             mem_re;
    logic [WORD-1:0]  mem_rdata;
    logic             stall;
    logic [RADDR-1:0] wb_dest;
    logic             wb_en;
    logic [WORD-1:0]  wb_data;
    logic             halted;

    modport master (
        output id_mem_w, id_mem_r, id_wb_en,
        output id_terminate, id_alu_op,
        output id_reg_rs, id_reg_rt, id_reg_dest,
        output id_alu_1, id_alu_2, id_st_data,
        output alu_result, mem_rdata,
        input  ex_alu_op, ex_opa, ex_opb,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  stall, wb_dest, wb_en, wb_data, halted
    );

    modport slave (
        input  id_mem_w, id_mem_r, id_wb_en,
        input  id_terminate, id_alu_op,
        input  id_reg_rs, id_reg_rt, id_reg_dest,
        input  id_alu_1, id_alu_2, id_st_data,
        input  alu_result, mem_rdata,
        output ex_alu_op, ex_opa, ex_opb,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output stall, wb_dest, wb_en, wb_data, halted
    );
endinterface

// File: rtl/ex_mem_wb_backend_fwd_select.sv
// Per-operand bypass mux: the younger MEM slot beats
// the WB slot; index 0 never bypasses.
module fwd_select
    import ex_mem_wb_backend_pkg::*;
(
    input  logic [RADDR-1:0] idx,
    input  logic [WORD-1:0]  cap,
    input  logic             mem_wb_en,
    input  logic             mem_mem_r,
    input  logic [RADDR-1:0] mem_dest,
    input  logic [WORD-1:0]  mem_val,
    input  logic             wb_wb_en,
    input  logic [RADDR-1:0] wb_dest,
    input  logic [WORD-1:0]  wb_val,
    output logic [WORD-1:0]  val
);
    logic live;
    logic hit_mem;
    logic hit_wb;

    assign live = (idx != '0);
    assign hit_mem = live & mem_wb_en & ~mem_mem_r
                   & (mem_dest == idx);
    assign hit_wb = live & wb_wb_en & ~hit_mem
                  & (wb_dest == idx);

    always_comb begin
        val = cap;
        unique case (1'b1)
            hit_mem: val = mem_val;
            hit_wb:  val = wb_val;
            default: val = cap;
        endcase
    end
endmodule

// File: rtl/ex_mem_wb_backend.sv
// EX/MEM/WB slots, operand bypass, load-use stall
// and sticky halt for the back half of the pipeline.
module ex_mem_wb_backend
    import ex_mem_wb_backend_pkg::*;
(
    input logic               clk,
    input logic               rst,
    ex_mem_wb_backend_if.slave bus
);
    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d, mem_d, wb_d;
    logic halted_q;
    logic hazard;
    logic mem_fwd_en;
    logic wb_fwd_en;
    logic [WORD-1:0] opa, opb, st_fwd;
    logic unused_wb;

    assign mem_fwd_en = mem_q.valid & mem_q.wb_en;
    assign wb_fwd_en  = wb_q.valid & wb_q.wb_en;

    fwd_select u_fwd_a (
        .idx(ex_q.rs), .cap(ex_q.op1),
        .mem_wb_en(mem_fwd_en), .mem_mem_r(mem_q.mem_r),
        .mem_dest(mem_q.dest), .mem_val(mem_q.result),
        .wb_wb_en(wb_fwd_en), .wb_dest(wb_q.dest),
        .wb_val(wb_q.result), .val(opa)
    );

    fwd_select u_fwd_b (
        .idx(ex_q.rt), .cap(ex_q.op2),
        .mem_wb_en(mem_fwd_en), .mem_mem_r(mem_q.mem_r),
        .mem_dest(mem_q.dest), .mem_val(mem_q.result),
        .wb_wb_en(wb_fwd_en), .wb_dest(wb_q.dest),
        .wb_val(wb_q.result), .val(opb)
    );

    fwd_select u_fwd_st (
        .idx(ex_q.rt), .cap(ex_q.st_data),
        .mem_wb_en(mem_fwd_en), .mem_mem_r(mem_q.mem_r),
        .mem_dest(mem_q.dest), .mem_val(mem_q.result),
        .wb_wb_en(wb_fwd_en), .wb_dest(wb_q.dest),
        .wb_val(wb_q.result), .val(st_fwd)
    );

    // Load data only exists in WB, so a dependent must wait one slot.
    assign hazard = ex_q.valid & ex_q.mem_r & ex_q.wb_en
                  & (ex_q.dest != '0)
                  & ((ex_q.dest == bus.id_reg_rs)
                   | (ex_q.dest == bus.id_reg_rt));

    always_comb begin
        ex_d = '0;
        if (!hazard) begin
            ex_d.valid     = 1'b1;
            ex_d.mem_w     = bus.id_mem_w;
            ex_d.mem_r     = bus.id_mem_r;
            ex_d.wb_en     = bus.id_wb_en;
            ex_d.terminate = bus.id_terminate;
            ex_d.alu_op    = bus.id_alu_op;
            ex_d.rs        = bus.id_reg_rs;
            ex_d.rt        = bus.id_reg_rt;
            ex_d.dest      = bus.id_reg_dest;
            ex_d.op1       = bus.id_alu_1;
            ex_d.op2       = bus.id_alu_2;
            ex_d.st_data   = bus.id_st_data;
        end
    end

    always_comb begin
        mem_d         = ex_q;
        mem_d.op1     = opa;
        mem_d.op2     = opb;
        mem_d.st_data = st_fwd;
        mem_d.result  = bus.alu_result;
    end

    always_comb begin
        wb_d = mem_q;
        if (mem_q.mem_r) wb_d.result = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            halted_q <= wb_q.valid & wb_q.terminate;
        end
    end

    assign bus.ex_alu_op = ex_q.alu_op;
    assign bus.ex_opa    = opa;
    assign bus.ex_opb    = opb;
    assign bus.mem_addr  = mem_q.result;
    assign bus.mem_wdata = mem_q.st_data;
    assign bus.mem_we    = mem_q.valid & mem_q.mem_w & ~halted_q;
    assign bus.mem_re    = mem_q.valid & mem_q.mem_r & ~halted_q;
    assign bus.stall     = hazard & ~halted_q;
    assign bus.wb_dest   = wb_q.dest;
    assign bus.wb_en     = wb_q.valid & wb_q.wb_en & ~halted_q;
    assign bus.wb_data   = wb_q.result;
    assign bus.halted    = halted_q;

    assign unused_wb = ^{wb_q.mem_w, wb_q.mem_r, wb_q.alu_op,
                         wb_q.rs, wb_q.rt, wb_q.op1,
                         wb_q.op2, wb_q.st_data};
endmodule

// File: tb/tb_ex_mem_wb_backend.sv
// Directed vector bench for ex_mem_wb_backend:
// per-cycle table plus halt and reset sequences.
module tb_ex_mem_wb_backend;
    logic clk;
    logic rst;
    int total;
    int bad;

    ex_mem_wb_backend_if bus();

    ex_mem_wb_backend dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] CA = 32'd16;
    localparam logic [31:0] CB = 32'd8;
    localparam logic [31:0] CS = 32'd4;
    localparam logic [31:0] CW = 32'd2;
    localparam logic [31:0] CM = 32'd1;
    localparam int NV = 21;

    typedef struct {
        logic [31:0] wbe, mr, mw, rd, rs, rt;
        logic [31:0] a1, a2, sd, alu, rdat, chk;
        logic [31:0] eopa, eopb, est;
        logic [31:0] ewbe, ewbd, ewdat, ewe, ewd;
    } vec_t;

    vec_t tbl [NV];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.id_wb_en     = v.wbe[0];
        bus.id_mem_r     = v.mr[0];
        bus.id_mem_w     = v.mw[0];
        bus.id_terminate = 1'b0;
        bus.id_alu_op    = 4'h0;
        bus.id_reg_dest  = v.rd[4:0];
        bus.id_reg_rs    = v.rs[4:0];
        bus.id_reg_rt    = v.rt[4:0];
        bus.id_alu_1     = v.a1;
        bus.id_alu_2     = v.a2;
        bus.id_st_data   = v.sd;
        bus.alu_result   = v.alu;
        bus.mem_rdata    = v.rdat;
    endtask

    task automatic drv(input logic wbe, input logic mr,
                       input logic [4:0] rd,
                       input logic [4:0] rs,
                       input logic term,
                       input logic [31:0] alu);
        bus.id_wb_en     = wbe;
        bus.id_mem_r     = mr;
        bus.id_mem_w     = 1'b0;
        bus.id_terminate = term;
        bus.id_alu_op    = 4'h0;
        bus.id_reg_dest  = rd;
        bus.id_reg_rs    = rs;
        bus.id_reg_rt    = 5'd0;
        bus.id_alu_1     = 32'h0;
        bus.id_alu_2     = 32'h0;
        bus.id_st_data   = 32'h0;
        bus.alu_result   = alu;
        bus.mem_rdata    = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        tbl[0]  = '{1,0,0,3,0,0,1,2,0, 0,0, CS|CW,
                    0,0,0, 0,0,0, 0,0};
        tbl[1]  = '{1,0,0,1,0,0,0,0,0, 'h11,0, CS,
                    0,0,0, 0,0,0, 0,0};
        tbl[2]  = '{1,0,0,7,1,0,'hDEAD,2,0, 5,0, 0,
                    0,0,0, 0,0,0, 0,0};
        tbl[3]  = '{0,0,0,0,0,0,'h1234,0,0, 'h3333,0, CA|CW,
                    5,0,0, 1,3,'h11, 0,0};
        tbl[4]  = '{1,0,0,2,0,0,0,0,0, 0,0, CA|CW,
                    'h1234,0,0, 1,1,5, 0,0};
        tbl[5]  = '{1,0,0,2,0,0,0,0,0, 'hA,0, CW,
                    0,0,0, 1,7,'h3333, 0,0};
        tbl[6]  = '{0,0,0,0,0,2,0,'hFFFF,0, 'hB,0, CW,
                    0,0,0, 0,0,0, 0,0};
        tbl[7]  = '{0,0,0,0,0,0,0,0,0, 0,0, CB|CW,
                    0,'hB,0, 1,2,'hA, 0,0};
        tbl[8]  = '{1,1,0,4,0,0,'h100,0,0, 0,0, CS|CW,
                    0,0,0, 1,2,'hB, 0,0};
        tbl[9]  = '{1,0,0,5,4,0,'hBAD,0,0, 'h100,0, CS,
                    0,0,1, 0,0,0, 0,0};
        tbl[10] = '{1,0,0,5,4,0,'hBAD,0,0, 0,'h77, CS,
                    0,0,0, 0,0,0, 0,0};
        tbl[11] = '{0,0,0,0,0,0,0,0,0, 'h78,0, CA|CW,
                    'h77,0,0, 1,4,'h77, 0,0};
        tbl[12] = '{1,1,0,0,0,0,0,0,0, 0,0, CW,
                    0,0,0, 0,0,0, 0,0};
        tbl[13] = '{0,0,0,0,0,0,0,0,0, 'h200,0, CS|CW,
                    0,0,0, 1,5,'h78, 0,0};
        tbl[14] = '{1,1,0,8,0,0,0,0,0, 0,'h55, CS|CW,
                    0,0,0, 0,0,0, 0,0};
        tbl[15] = '{0,0,0,0,0,9,0,0,0, 'h300,0, CS|CW,
                    0,0,0, 1,0,'h55, 0,0};
        tbl[16] = '{1,0,0,6,0,0,0,0,0, 0,'h66, 0,
                    0,0,0, 0,0,0, 0,0};
        tbl[17] = '{0,0,1,0,0,6,'h40,0,1, 'h99,0, CW,
                    0,0,0, 1,8,'h66, 0,0};
        tbl[18] = '{0,0,0,0,0,0,0,0,0, 'h40,0, CB|CM,
                    0,'h99,0, 0,0,0, 0,0};
        tbl[19] = '{0,0,0,0,0,0,0,0,0, 0,0, CM|CW,
                    0,0,0, 1,6,'h99, 1,'h99};
        tbl[20] = '{0,0,0,0,0,0,0,0,0, 0,0, CM,
                    0,0,0, 0,0,0, 0,0};

        // reset held with busy inputs
        rst = 1'b0;
        drv(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 32'hFFFF);
        bus.id_mem_w  = 1'b1;
        bus.mem_rdata = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        check("rst wb_en", 32'(bus.wb_en), 0);
        check("rst wb_data", bus.wb_data, 0);
        check("rst wb_dest", 32'(bus.wb_dest), 0);
        check("rst stall", 32'(bus.stall), 0);
        check("rst halted", 32'(bus.halted), 0);
        check("rst ex_opa", bus.ex_opa, 0);
        check("rst mem_we", 32'(bus.mem_we), 0);
        check("rst mem_addr", bus.mem_addr, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            #2;
            if (tbl[i].chk[4])
                check($sformatf("v%0d ex_opa", i),
                      bus.ex_opa, tbl[i].eopa);
            if (tbl[i].chk[3])
                check($sformatf("v%0d ex_opb", i),
                      bus.ex_opb, tbl[i].eopb);
            if (tbl[i].chk[2])
                check($sformatf("v%0d stall", i),
                      32'(bus.stall), tbl[i].est);
            if (tbl[i].chk[1]) begin
                check($sformatf("v%0d wb_en", i),
                      32'(bus.wb_en), tbl[i].ewbe);
                check($sformatf("v%0d wb_dest", i),
                      32'(bus.wb_dest), tbl[i].ewbd);
                check($sformatf("v%0d wb_data", i),
                      bus.wb_data, tbl[i].ewdat);
            end
            if (tbl[i].chk[0]) begin
                check($sformatf("v%0d mem_we", i),
                      32'(bus.mem_we), tbl[i].ewe);
                check($sformatf("v%0d mem_wdata", i),
                      bus.mem_wdata, tbl[i].ewd);
            end
            step();
        end

        // terminate, then loads that would otherwise stall
        drv(1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 32'h0);
        step();
        drv(1'b1, 1'b0, 5'd10, 5'd0, 1'b0, 32'h9);
        step();
        drv(1'b1, 1'b1, 5'd12, 5'd0, 1'b0, 32'h0);
        step();
        drv(1'b1, 1'b1, 5'd13, 5'd0, 1'b0, 32'h0);
        #2;
        check("term wb_en", 32'(bus.wb_en), 1);
        check("term wb_dest", 32'(bus.wb_dest), 9);
        check("term wb_data", bus.wb_data, 9);
        check("term halted", 32'(bus.halted), 0);
        step();
        drv(1'b1, 1'b0, 5'd14, 5'd13, 1'b0, 32'h0);
        #2;
        check("halt set", 32'(bus.halted), 1);
        check("halt wb_en", 32'(bus.wb_en), 0);
        check("halt stall", 32'(bus.stall), 0);
        check("halt mem_re", 32'(bus.mem_re), 0);
        step();
        check("halt sticky", 32'(bus.halted), 1);
        check("halt wb_en2", 32'(bus.wb_en), 0);
        #1;
        rst = 1'b0;
        #1;
        check("arst halted", 32'(bus.halted), 0);
        check("arst wb_en", 32'(bus.wb_en), 0);
        check("arst stall", 32'(bus.stall), 0);
        check("arst wb_dest", 32'(bus.wb_dest), 0);
        #1;
        rst = 1'b1;

        // reset while an add is in flight
        drv(1'b1, 1'b0, 5'd14, 5'd0, 1'b0, 32'h0);
        step();
        drv(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h14);
        step();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        drv(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("flush%0d wb_en", k),
                  32'(bus.wb_en), 0);
            check($sformatf("flush%0d wb_data", k),
                  bus.wb_data, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
